// File: rtl/vip_uart_rx_fifo.sv
// vip_uart_rx_fifo
// UART receiver VIP: configurable data width (5..9), 1 or 2 stop bits and
// optional parity. Frames are pushed into a show-ahead FIFO with a valid/ready
// pop, per-word parity/framing flags and a sticky overflow flag.
// Optional parity support is compiled in when VIP_UART_RX_PARITY_EN is defined;
// without it the parity parameter is ignored and o_rd_perr always reads 0.
module vip_uart_rx_fifo #(
   parameter int scaler    = 8,
   parameter int data_bits = 8,
   parameter int stop_bits = 1,
   parameter int parity    = 0,
   parameter int fifo_log2 = 2
) (
   input  logic                 i_clk,
   input  logic                 i_nrst,
   input  logic                 i_rx,
   output logic                 o_rd_valid,
   input  logic                 i_rd_ready,
   output logic [8:0]           o_rd_data,
   output logic                 o_rd_perr,
   output logic                 o_rd_ferr,
   output logic [fifo_log2:0]   o_count,
   output logic                 o_overflow,
   input  logic                 i_ovf_clr
);

   localparam int DEPTH = 1 << fifo_log2;
   localparam int CW    = $clog2(2 * scaler);
   localparam int PW    = fifo_log2;
   localparam int WW    = 11;

   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_MID   = CW'(scaler - 1);
   localparam logic [CW-1:0] CNT_END   = CW'(2 * scaler - 1);
   localparam logic [3:0]    BIT_ZERO  = 4'd0;
   localparam logic [3:0]    BIT_LAST  = 4'(data_bits - 1);
   localparam logic [3:0]    STOP_LAST = 4'(stop_bits - 1);
   localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(DEPTH);
   localparam logic [PW:0]   CNT_EMPTY = {(PW + 1){1'b0}};
   localparam logic [PW:0]   COUNT_ONE = (PW + 1)'(1);
   localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [WW-1:0] WORD_ZERO = {WW{1'b0}};

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef VIP_UART_RX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic       PAR_EN    = (parity != 0);
   localparam logic       PAR_ODD   = (parity == 1);
`else
   // Parity is not built in: the mode parameter has no effect.
   localparam logic       PAR_EN    = (parity < 0) && (parity >= 0);
`endif
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Line synchroniser and edge-detect delay
   logic            rx_meta_r;
   logic            rx_sync_r;
   logic            rx_dly_r;

   // Frame state machine
   logic [2:0]      state_r;
   logic [CW-1:0]   cnt_r;
   logic [3:0]      bitpos_r;
   logic [8:0]      shift_r;
   logic            ferr_r;
`ifdef VIP_UART_RX_PARITY_EN
   logic            perr_r;
`endif
   logic            perr_bit_s;
   logic            push_s;
   logic [WW-1:0]   push_word_s;

   // FIFO
   logic [WW-1:0]   mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [WW-1:0]   head_r;
   logic            pop_s;
   logic            full_s;
   logic            push_ok_s;
   logic            drop_s;
   logic [PW:0]     count_nxt_s;
   logic [PW-1:0]   rd_ptr_nxt_s;
   logic [WW-1:0]   head_nxt_s;

`ifdef VIP_UART_RX_PARITY_EN
   assign perr_bit_s = perr_r;
`else
   assign perr_bit_s = PAR_EN;
`endif

   // Two-flop synchroniser on the asynchronous line plus one delay flop for edge detection
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_dly_r  <= 1'b1;
      end else begin
         rx_meta_r <= i_rx;
         rx_sync_r <= rx_meta_r;
         rx_dly_r  <= rx_sync_r;
      end
   end

   // Frame receiver: sample every bit at its middle, restart timing on each start edge
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_r  <= ST_IDLE;
         cnt_r    <= CNT_ZERO;
         bitpos_r <= BIT_ZERO;
         shift_r  <= 9'd0;
         ferr_r   <= 1'b0;
`ifdef VIP_UART_RX_PARITY_EN
         perr_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= CNT_ZERO;
               // A falling edge is needed; a line held low never restarts a frame.
               if (rx_dly_r && !rx_sync_r) begin
                  state_r <= ST_START;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_START: begin
               if ((cnt_r == CNT_MID) && rx_sync_r) begin
                  // Line back high at mid start bit: glitch, not a frame.
                  state_r <= ST_IDLE;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_END) begin
                  state_r  <= ST_DATA;
                  cnt_r    <= CNT_ZERO;
                  bitpos_r <= BIT_ZERO;
                  shift_r  <= 9'd0;
                  ferr_r   <= 1'b0;
`ifdef VIP_UART_RX_PARITY_EN
                  perr_r   <= 1'b0;
`endif
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (cnt_r == CNT_MID) begin
                  shift_r[bitpos_r] <= rx_sync_r;
               end else begin
                  shift_r <= shift_r;
               end
               if (cnt_r == CNT_END) begin
                  cnt_r <= CNT_ZERO;
                  if (bitpos_r == BIT_LAST) begin
                     // bitpos is reused as the stop-bit index.
                     bitpos_r <= BIT_ZERO;
`ifdef VIP_UART_RX_PARITY_EN
                     state_r  <= PAR_EN ? ST_PARITY : ST_STOP;
`else
                     state_r  <= ST_STOP;
`endif
                  end else begin
                     bitpos_r <= bitpos_r + 4'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
`ifdef VIP_UART_RX_PARITY_EN
            ST_PARITY: begin
               if (cnt_r == CNT_MID) begin
                  // Odd mode expects the XOR over payload and parity bit to be 1.
                  perr_r <= (^shift_r) ^ rx_sync_r ^ PAR_ODD;
               end else begin
                  perr_r <= perr_r;
               end
               if (cnt_r == CNT_END) begin
                  state_r <= ST_STOP;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
`endif
            ST_STOP: begin
               if (cnt_r == CNT_MID) begin
                  if (!rx_sync_r) begin
                     ferr_r <= 1'b1;
                  end else begin
                     ferr_r <= ferr_r;
                  end
                  if (bitpos_r == STOP_LAST) begin
                     // Word is pushed now; leaving early lets the next start edge be seen.
                     state_r <= ST_IDLE;
                     cnt_r   <= CNT_ZERO;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end else if (cnt_r == CNT_END) begin
                  cnt_r    <= CNT_ZERO;
                  bitpos_r <= bitpos_r + 4'd1;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= CNT_ZERO;
            end
         endcase
      end
   end

   // Push request at mid-bit of the last stop bit; the current sample feeds ferr directly
   always_comb begin
      push_s = 1'b0;
      if ((state_r == ST_STOP) && (cnt_r == CNT_MID) && (bitpos_r == STOP_LAST)) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
      push_word_s = {shift_r, perr_bit_s, ferr_r | ~rx_sync_r};
   end

   // FIFO bookkeeping: accept a push when not full or when a pop frees a slot this cycle
   always_comb begin
      pop_s       = o_rd_valid & i_rd_ready;
      full_s      = (o_count == CNT_FULL);
      push_ok_s   = push_s & (~full_s | pop_s);
      drop_s      = push_s & full_s & ~pop_s;
      count_nxt_s = o_count;
      case ({push_ok_s, pop_s})
         2'b10:   count_nxt_s = o_count + COUNT_ONE;
         2'b01:   count_nxt_s = o_count - COUNT_ONE;
         default: count_nxt_s = o_count;
      endcase
      rd_ptr_nxt_s = rd_ptr_r;
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      // Next head: bypass the incoming word when it lands where the head will be.
      head_nxt_s = WORD_ZERO;
      if (count_nxt_s == CNT_EMPTY) begin
         head_nxt_s = WORD_ZERO;
      end else if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
         head_nxt_s = push_word_s;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // FIFO storage write
   always_ff @(posedge i_clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_word_s;
      end
   end

   // FIFO pointers, count, registered show-ahead head and sticky overflow
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         o_count    <= CNT_EMPTY;
         o_rd_valid <= 1'b0;
         head_r     <= WORD_ZERO;
         o_overflow <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         rd_ptr_r   <= rd_ptr_nxt_s;
         o_count    <= count_nxt_s;
         o_rd_valid <= (count_nxt_s != CNT_EMPTY);
         head_r     <= head_nxt_s;
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop_s) begin
            o_overflow <= 1'b1;
         end else if (i_ovf_clr) begin
            o_overflow <= 1'b0;
         end
      end
   end

   assign o_rd_data = head_r[10:2];
   assign o_rd_perr = head_r[1];
   assign o_rd_ferr = head_r[0];

endmodule

// File: tb/tb_vip_uart_rx_fifo.sv
// Testbench for vip_uart_rx_fifo: four instances (defaults, 5-bit/2-stop,
// depth-2 FIFO, even parity) driven by serial frames; expected words are
// queued when a frame is sent and compared when the FIFO presents them.
`timescale 1ns/1ps
module tb_vip_uart_rx_fifo;
   localparam int BIT = 16;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   logic rx_def, ready_def, clr_def, valid_def, perr_def, ferr_def, ovf_def;
   logic [8:0] data_def;
   logic [2:0] count_def;
   logic rx_s2, ready_s2, clr_s2, valid_s2, perr_s2, ferr_s2, ovf_s2;
   logic [8:0] data_s2;
   logic [2:0] count_s2;
   logic rx_f1, ready_f1, clr_f1, valid_f1, perr_f1, ferr_f1, ovf_f1;
   logic [8:0] data_f1;
   logic [1:0] count_f1;
   logic rx_par, ready_par, clr_par, valid_par, perr_par, ferr_par, ovf_par;
   logic [8:0] data_par;
   logic [2:0] count_par;

   int n_checks = 0;
   int n_fail = 0;
   logic [10:0] q_def[$];
   logic [10:0] q_s2[$];
   logic [10:0] q_f1[$];
   logic [10:0] q_par[$];

   vip_uart_rx_fifo u_def (
      .i_clk(clk), .i_nrst(nrst), .i_rx(rx_def), .o_rd_valid(valid_def), .i_rd_ready(ready_def),
      .o_rd_data(data_def), .o_rd_perr(perr_def), .o_rd_ferr(ferr_def), .o_count(count_def),
      .o_overflow(ovf_def), .i_ovf_clr(clr_def));
   vip_uart_rx_fifo #(.data_bits(5), .stop_bits(2)) u_s2 (
      .i_clk(clk), .i_nrst(nrst), .i_rx(rx_s2), .o_rd_valid(valid_s2), .i_rd_ready(ready_s2),
      .o_rd_data(data_s2), .o_rd_perr(perr_s2), .o_rd_ferr(ferr_s2), .o_count(count_s2),
      .o_overflow(ovf_s2), .i_ovf_clr(clr_s2));
   vip_uart_rx_fifo #(.fifo_log2(1)) u_f1 (
      .i_clk(clk), .i_nrst(nrst), .i_rx(rx_f1), .o_rd_valid(valid_f1), .i_rd_ready(ready_f1),
      .o_rd_data(data_f1), .o_rd_perr(perr_f1), .o_rd_ferr(ferr_f1), .o_count(count_f1),
      .o_overflow(ovf_f1), .i_ovf_clr(clr_f1));
   vip_uart_rx_fifo #(.parity(2)) u_par (
      .i_clk(clk), .i_nrst(nrst), .i_rx(rx_par), .o_rd_valid(valid_par), .i_rd_ready(ready_par),
      .o_rd_data(data_par), .o_rd_perr(perr_par), .o_rd_ferr(ferr_par), .o_count(count_par),
      .o_overflow(ovf_par), .i_ovf_clr(clr_par));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rx(input int inst, input logic v);
      case (inst)
         0: rx_def = v;
         1: rx_s2 = v;
         2: rx_f1 = v;
         default: rx_par = v;
      endcase
   endtask

   // par_bit < 0 means no parity bit is sent; stops[i] is the level of stop bit i
   task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                             input int par_bit, input logic [1:0] stops, input int nstop);
      drive_rx(inst, 1'b0);
      repeat (BIT) tick();
      for (int i = 0; i < nbits; i++) begin
         drive_rx(inst, data[i]);
         repeat (BIT) tick();
      end
      if (par_bit >= 0) begin
         drive_rx(inst, par_bit[0]);
         repeat (BIT) tick();
      end
      for (int i = 0; i < nstop; i++) begin
         drive_rx(inst, stops[i]);
         repeat (BIT) tick();
      end
      drive_rx(inst, 1'b1);
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({valid_def, data_def, perr_def, ferr_def, count_def, ovf_def} !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_def: got %h expected 0", {valid_def, data_def, perr_def, ferr_def, count_def, ovf_def});
      end
      n_checks++;
      if ({valid_s2, data_s2, perr_s2, ferr_s2, count_s2, ovf_s2} !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_s2: got %h expected 0", {valid_s2, data_s2, perr_s2, ferr_s2, count_s2, ovf_s2});
      end
      n_checks++;
      if ({valid_f1, data_f1, perr_f1, ferr_f1, count_f1, ovf_f1} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_f1: got %h expected 0", {valid_f1, data_f1, perr_f1, ferr_f1, count_f1, ovf_f1});
      end
      n_checks++;
      if ({valid_par, data_par, perr_par, ferr_par, count_par, ovf_par} !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_par: got %h expected 0", {valid_par, data_par, perr_par, ferr_par, count_par, ovf_par});
      end
      nrst = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_basic();
      logic [10:0] exp_w;
      q_def.push_back({9'h0A5, 1'b0, 1'b0});
      fork
         send_frame(0, 9'h0A5, 8, -1, 2'b11, 1);
         begin
            repeat (154) tick();
            n_checks++;
            if (valid_def !== 1'b0) begin
               n_fail++;
               $display("FAIL basic_early_valid: got %b expected 0", valid_def);
            end
            tick();
            n_checks++;
            if (valid_def !== 1'b1) begin
               n_fail++;
               $display("FAIL basic_latency_valid: got %b expected 1", valid_def);
            end
            exp_w = q_def.pop_front();
            n_checks++;
            if ({data_def, perr_def, ferr_def} !== exp_w) begin
               n_fail++;
               $display("FAIL basic_word: got %h expected %h", {data_def, perr_def, ferr_def}, exp_w);
            end
            n_checks++;
            if (count_def !== 3'd1) begin
               n_fail++;
               $display("FAIL basic_count: got %0d expected 1", count_def);
            end
         end
      join
      // Second cycle of ready sees an empty FIFO and must be ignored.
      ready_def = 1'b1;
      repeat (2) tick();
      ready_def = 1'b0;
      n_checks++;
      if ({valid_def, count_def} !== 4'b0000) begin
         n_fail++;
         $display("FAIL basic_pop_empty: got valid=%b count=%0d expected 0/0", valid_def, count_def);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] pats [4];
      logic [10:0] exp_w;
      pats[0] = 9'h000; pats[1] = 9'h0FF; pats[2] = 9'h03C; pats[3] = 9'h081;
      for (int i = 0; i < 4; i++) begin
         q_def.push_back({pats[i], 1'b0, 1'b0});
         send_frame(0, pats[i], 8, -1, 2'b11, 1);
      end
      tick();
      n_checks++;
      if (count_def !== 3'd4) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d expected 4", count_def);
      end
      ready_def = 1'b1;
      while (q_def.size() > 0) begin
         exp_w = q_def.pop_front();
         n_checks++;
         if ({valid_def, data_def, perr_def, ferr_def} !== {1'b1, exp_w}) begin
            n_fail++;
            $display("FAIL b2b_word: got %h expected %h", {valid_def, data_def, perr_def, ferr_def}, {1'b1, exp_w});
         end
         tick();
      end
      ready_def = 1'b0;
      n_checks++;
      if ({valid_def, count_def} !== 4'b0000) begin
         n_fail++;
         $display("FAIL b2b_drained: got valid=%b count=%0d expected 0/0", valid_def, count_def);
      end
   endtask

   task automatic test_stop2();
      logic [10:0] exp_w;
      q_s2.push_back({9'h01F, 1'b0, 1'b0});
      send_frame(1, 9'h1FF, 5, -1, 2'b11, 2);
      repeat (BIT) tick();
      q_s2.push_back({9'h000, 1'b0, 1'b1});
      send_frame(1, 9'h000, 5, -1, 2'b01, 2);
      repeat (BIT) tick();
      q_s2.push_back({9'h015, 1'b0, 1'b1});
      send_frame(1, 9'h015, 5, -1, 2'b10, 2);
      repeat (BIT) tick();
      n_checks++;
      if (count_s2 !== 3'd3) begin
         n_fail++;
         $display("FAIL stop2_count: got %0d expected 3", count_s2);
      end
      ready_s2 = 1'b1;
      while (q_s2.size() > 0) begin
         exp_w = q_s2.pop_front();
         n_checks++;
         if ({valid_s2, data_s2, perr_s2, ferr_s2} !== {1'b1, exp_w}) begin
            n_fail++;
            $display("FAIL stop2_word: got %h expected %h", {valid_s2, data_s2, perr_s2, ferr_s2}, {1'b1, exp_w});
         end
         tick();
      end
      ready_s2 = 1'b0;
   endtask

   task automatic test_parity();
      logic [10:0] exp_w;
      // Even parity: 0x07 has three ones, so a parity bit of 0 is wrong and 1 is right.
      q_par.push_back({9'h007, 1'b1, 1'b0});
      send_frame(3, 9'h007, 8, 0, 2'b11, 1);
      q_par.push_back({9'h007, 1'b0, 1'b0});
      send_frame(3, 9'h007, 8, 1, 2'b11, 1);
      q_par.push_back({9'h003, 1'b0, 1'b0});
      send_frame(3, 9'h003, 8, 0, 2'b11, 1);
      tick();
      n_checks++;
      if (count_par !== 3'd3) begin
         n_fail++;
         $display("FAIL parity_count: got %0d expected 3", count_par);
      end
      ready_par = 1'b1;
      while (q_par.size() > 0) begin
         exp_w = q_par.pop_front();
         n_checks++;
         if ({valid_par, data_par, perr_par, ferr_par} !== {1'b1, exp_w}) begin
            n_fail++;
            $display("FAIL parity_word: got %h expected %h", {valid_par, data_par, perr_par, ferr_par}, {1'b1, exp_w});
         end
         tick();
      end
      ready_par = 1'b0;
   endtask

   task automatic test_overflow();
      logic [10:0] exp_w;
      q_f1.push_back({9'h011, 1'b0, 1'b0});
      send_frame(2, 9'h011, 8, -1, 2'b11, 1);
      q_f1.push_back({9'h022, 1'b0, 1'b0});
      send_frame(2, 9'h022, 8, -1, 2'b11, 1);
      // Third frame is dropped; the clear is held through its push cycle and must lose.
      clr_f1 = 1'b1;
      fork
         send_frame(2, 9'h033, 8, -1, 2'b11, 1);
         begin
            repeat (155) tick();
            clr_f1 = 1'b0;
            n_checks++;
            if (ovf_f1 !== 1'b1) begin
               n_fail++;
               $display("FAIL ovf_set_wins: got %b expected 1", ovf_f1);
            end
         end
      join
      n_checks++;
      if (count_f1 !== 2'd2) begin
         n_fail++;
         $display("FAIL ovf_count: got %0d expected 2", count_f1);
      end
      clr_f1 = 1'b1;
      tick();
      clr_f1 = 1'b0;
      n_checks++;
      if (ovf_f1 !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %b expected 0", ovf_f1);
      end
      ready_f1 = 1'b1;
      while (q_f1.size() > 0) begin
         exp_w = q_f1.pop_front();
         n_checks++;
         if ({valid_f1, data_f1, perr_f1, ferr_f1} !== {1'b1, exp_w}) begin
            n_fail++;
            $display("FAIL ovf_word: got %h expected %h", {valid_f1, data_f1, perr_f1, ferr_f1}, {1'b1, exp_w});
         end
         tick();
      end
      ready_f1 = 1'b0;
   endtask

   task automatic test_full_pop();
      logic [10:0] exp_w;
      q_f1.push_back({9'h044, 1'b0, 1'b0});
      send_frame(2, 9'h044, 8, -1, 2'b11, 1);
      q_f1.push_back({9'h055, 1'b0, 1'b0});
      send_frame(2, 9'h055, 8, -1, 2'b11, 1);
      q_f1.push_back({9'h066, 1'b0, 1'b0});
      fork
         send_frame(2, 9'h066, 8, -1, 2'b11, 1);
         begin
            repeat (154) tick();
            exp_w = q_f1.pop_front();
            n_checks++;
            if ({valid_f1, data_f1, perr_f1, ferr_f1} !== {1'b1, exp_w}) begin
               n_fail++;
               $display("FAIL fullpop_head: got %h expected %h", {valid_f1, data_f1, perr_f1, ferr_f1}, {1'b1, exp_w});
            end
            ready_f1 = 1'b1;
            tick();
            ready_f1 = 1'b0;
            n_checks++;
            if ({ovf_f1, count_f1} !== 3'b010) begin
               n_fail++;
               $display("FAIL fullpop_state: got ovf=%b count=%0d expected 0/2", ovf_f1, count_f1);
            end
         end
      join
      ready_f1 = 1'b1;
      while (q_f1.size() > 0) begin
         exp_w = q_f1.pop_front();
         n_checks++;
         if ({valid_f1, data_f1, perr_f1, ferr_f1} !== {1'b1, exp_w}) begin
            n_fail++;
            $display("FAIL fullpop_word: got %h expected %h", {valid_f1, data_f1, perr_f1, ferr_f1}, {1'b1, exp_w});
         end
         tick();
      end
      ready_f1 = 1'b0;
   endtask

   task automatic test_glitch();
      logic [10:0] exp_w;
      drive_rx(0, 1'b0);
      repeat (6) tick();
      drive_rx(0, 1'b1);
      repeat (200) tick();
      n_checks++;
      if ({valid_def, count_def} !== 4'b0000) begin
         n_fail++;
         $display("FAIL glitch_nopush: got valid=%b count=%0d expected 0/0", valid_def, count_def);
      end
      q_def.push_back({9'h05A, 1'b0, 1'b0});
      send_frame(0, 9'h05A, 8, -1, 2'b11, 1);
      tick();
      exp_w = q_def.pop_front();
      n_checks++;
      if ({valid_def, data_def, perr_def, ferr_def, count_def} !== {1'b1, exp_w, 3'd1}) begin
         n_fail++;
         $display("FAIL glitch_after: got %h expected %h", {valid_def, data_def, perr_def, ferr_def, count_def}, {1'b1, exp_w, 3'd1});
      end
      ready_def = 1'b1;
      tick();
      ready_def = 1'b0;
   endtask

   task automatic test_break();
      logic [10:0] exp_w;
      q_def.push_back({9'h000, 1'b0, 1'b1});
      drive_rx(0, 1'b0);
      repeat (12 * BIT) tick();
      drive_rx(0, 1'b1);
      repeat (4 * BIT) tick();
      exp_w = q_def.pop_front();
      n_checks++;
      if ({valid_def, data_def, perr_def, ferr_def, count_def} !== {1'b1, exp_w, 3'd1}) begin
         n_fail++;
         $display("FAIL break_word: got %h expected %h", {valid_def, data_def, perr_def, ferr_def, count_def}, {1'b1, exp_w, 3'd1});
      end
      ready_def = 1'b1;
      tick();
      ready_def = 1'b0;
   endtask

   task automatic test_reset_midframe();
      logic [10:0] exp_w;
      // This word is discarded by the reset, so it is not queued.
      send_frame(0, 9'h033, 8, -1, 2'b11, 1);
      tick();
      n_checks++;
      if (count_def !== 3'd1) begin
         n_fail++;
         $display("FAIL rstmid_prefill: got %0d expected 1", count_def);
      end
      drive_rx(0, 1'b0);
      repeat (4 * BIT) tick();
      nrst = 1'b0;
      drive_rx(0, 1'b1);
      tick();
      n_checks++;
      if ({valid_def, data_def, perr_def, ferr_def, count_def, ovf_def} !== 16'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got %h expected 0", {valid_def, data_def, perr_def, ferr_def, count_def, ovf_def});
      end
      nrst = 1'b1;
      repeat (2 * BIT) tick();
      n_checks++;
      if (valid_def !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_idle: got %b expected 0", valid_def);
      end
      q_def.push_back({9'h0C3, 1'b0, 1'b0});
      send_frame(0, 9'h0C3, 8, -1, 2'b11, 1);
      tick();
      exp_w = q_def.pop_front();
      n_checks++;
      if ({valid_def, data_def, perr_def, ferr_def, count_def} !== {1'b1, exp_w, 3'd1}) begin
         n_fail++;
         $display("FAIL rstmid_next: got %h expected %h", {valid_def, data_def, perr_def, ferr_def, count_def}, {1'b1, exp_w, 3'd1});
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nrst = 1'b0;
      rx_def = 1'b1; ready_def = 1'b0; clr_def = 1'b0;
      rx_s2 = 1'b1; ready_s2 = 1'b0; clr_s2 = 1'b0;
      rx_f1 = 1'b1; ready_f1 = 1'b0; clr_f1 = 1'b0;
      rx_par = 1'b1; ready_par = 1'b0; clr_par = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_stop2();
`ifdef VIP_UART_RX_PARITY_EN
      test_parity();
`endif
      test_overflow();
      test_full_pop();
      test_glitch();
      test_break();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
